// File: rtl/axi_io_pmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_io_pmp_pkg
// Purpose  : Shared constants and types for the IO-PMP AXI filter blocks.
// Revision : 1.0 - initial release
// ============================================================================
package axi_io_pmp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Physical address bits presented to the PMP checker
    localparam int PMP_LEN = 56;

    localparam int AXI_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        DRAIN = 2'd1,
        ERR   = 2'd2
    } rd_filter_state_e;

endpackage : axi_io_pmp_pkg
`default_nettype wire

// File: rtl/axi_io_pmp_rd_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_io_pmp_rd_filter_if
// Purpose  : AXI read-channel (AR + R) bundle used on both sides of the filter.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_io_pmp_rd_filter_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 64,
    parameter int ID_WIDTH     = 8,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1
);
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic [ARUSER_WIDTH-1:0] aruser;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [RUSER_WIDTH-1:0]  ruser;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arqos, arregion, aruser, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, ruser, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arqos, arregion, aruser, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, ruser, rvalid
    );

endinterface : axi_io_pmp_rd_filter_if
`default_nettype wire

// File: rtl/axi_io_pmp_err_burst.sv
`default_nettype none
// ============================================================================
// Module   : axi_io_pmp_err_burst
// Purpose  : Local DECERR response generator: captures id/len/user and emits
//            len+1 error beats (or a single beat when len is tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
module axi_io_pmp_err_burst
    import axi_io_pmp_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 1,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = AXI_LEN_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_load,
    input  wire logic [ID_WIDTH-1:0]   i_id,
    input  wire logic [LEN_WIDTH-1:0]  i_len,
    input  wire logic [USER_WIDTH-1:0] i_user,
    input  wire logic                  i_active,
    input  wire logic                  i_ready,
    output logic                       o_valid,
    output logic [ID_WIDTH-1:0]        o_id,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic [1:0]                 o_resp,
    output logic                       o_last,
    output logic [USER_WIDTH-1:0]      o_user,
    output logic                       o_done
);

    logic [LEN_WIDTH-1:0]  r_beat;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [ID_WIDTH-1:0]   r_id;
    logic [USER_WIDTH-1:0] r_user;
    logic                  w_hs;

    assign o_valid = i_active;
    assign o_id    = r_id;
    assign o_data  = '0;
    assign o_resp  = RESP_DECERR;
    assign o_last  = (r_beat == r_len);
    assign o_user  = r_user;
    assign w_hs    = i_active && i_ready;
    assign o_done  = w_hs && o_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_len  <= '0;
            r_id   <= '0;
            r_user <= '0;
        end else begin
            if (i_load) begin
                r_id   <= i_id;
                r_len  <= i_len;
                r_user <= i_user;
            end
            // Clearing on the last beat also covers len=255 wrapping to 0
            if (w_hs) begin
                r_beat <= o_last ? '0 : r_beat + 1'b1;
            end
        end
    end

endmodule : axi_io_pmp_err_burst
`default_nettype wire

// File: rtl/axi_io_pmp_rd_filter.sv
`default_nettype none
// ============================================================================
// Module   : axi_io_pmp_rd_filter
// Purpose  : IO-PMP read enforcement: forwards allowed ARs, answers denied
//            ARs locally with an in-order DECERR burst.
// Revision : 1.0 - initial release
// ============================================================================
module axi_io_pmp_rd_filter
    import axi_io_pmp_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = 8,
    parameter int ARUSER_WIDTH    = 1,
    parameter int RUSER_WIDTH     = 1,
    parameter int PLEN            = PMP_LEN,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    axi_io_pmp_rd_filter_if.slave   s_axi,
    axi_io_pmp_rd_filter_if.master  m_axi,
    output logic [PLEN-1:0]         pmp_addr_o,
    input  wire logic               pmp_allow_i,
    output logic [CNT_W-1:0]        outstanding_o
);

    localparam logic [CNT_W-1:0] c_max_outstanding = CNT_W'(MAX_OUTSTANDING);

    rd_filter_state_e r_state;
    rd_filter_state_e w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic w_room;
    logic w_s_arready;
    logic w_m_arvalid;
    logic w_s_rvalid;
    logic w_m_rready;
    logic w_err_load;
    logic w_err_sel;
    logic w_ar_hs;
    logic w_r_last_hs;

    logic                   w_eb_valid;
    logic [ID_WIDTH-1:0]    w_eb_id;
    logic [DATA_WIDTH-1:0]  w_eb_data;
    logic [1:0]             w_eb_resp;
    logic                   w_eb_last;
    logic [RUSER_WIDTH-1:0] w_eb_user;
    logic                   w_eb_done;

    assign w_room    = (r_cnt < c_max_outstanding);
    assign w_err_sel = (r_state == ERR);

    // AR payload is a zero-latency pass-through; only valid/ready are gated
    assign pmp_addr_o      = s_axi.araddr[PLEN-1:0];
    assign m_axi.arid      = s_axi.arid;
    assign m_axi.araddr    = s_axi.araddr;
    assign m_axi.arlen     = s_axi.arlen;
    assign m_axi.arsize    = s_axi.arsize;
    assign m_axi.arburst   = s_axi.arburst;
    assign m_axi.arlock    = s_axi.arlock;
    assign m_axi.arcache   = s_axi.arcache;
    assign m_axi.arprot    = s_axi.arprot;
    assign m_axi.arqos     = s_axi.arqos;
    assign m_axi.arregion  = s_axi.arregion;
    assign m_axi.aruser    = s_axi.aruser;
    assign m_axi.arvalid   = w_m_arvalid;
    assign s_axi.arready   = w_s_arready;

    assign s_axi.rid    = w_err_sel ? w_eb_id   : m_axi.rid;
    assign s_axi.rdata  = w_err_sel ? w_eb_data : m_axi.rdata;
    assign s_axi.rresp  = w_err_sel ? w_eb_resp : m_axi.rresp;
    assign s_axi.rlast  = w_err_sel ? w_eb_last : m_axi.rlast;
    assign s_axi.ruser  = w_err_sel ? w_eb_user : m_axi.ruser;
    assign s_axi.rvalid = w_s_rvalid;
    assign m_axi.rready = w_m_rready;

    assign outstanding_o = r_cnt;

    axi_io_pmp_err_burst #(
        .ID_WIDTH   (ID_WIDTH),
        .USER_WIDTH (RUSER_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (AXI_LEN_WIDTH)
    ) u_err_burst (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_err_load),
        .i_id     (s_axi.arid),
        .i_len    (s_axi.arlen),
        .i_user   (RUSER_WIDTH'(s_axi.aruser)),
        .i_active (w_err_sel),
        .i_ready  (s_axi.rready),
        .o_valid  (w_eb_valid),
        .o_id     (w_eb_id),
        .o_data   (w_eb_data),
        .o_resp   (w_eb_resp),
        .o_last   (w_eb_last),
        .o_user   (w_eb_user),
        .o_done   (w_eb_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_arready = 1'b0;
        w_m_arvalid = 1'b0;
        w_s_rvalid  = m_axi.rvalid;
        w_m_rready  = s_axi.rready;
        w_err_load  = 1'b0;

        unique case (r_state)
            PASS: begin
                if (pmp_allow_i) begin
                    w_m_arvalid = s_axi.arvalid && w_room;
                    w_s_arready = m_axi.arready && w_room;
                end else begin
                    // Denied ARs are always absorbed in one cycle
                    w_s_arready = 1'b1;
                    if (s_axi.arvalid) begin
                        w_err_load  = 1'b1;
                        w_state_nxt = (r_cnt == '0) ? ERR : DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Earlier forwarded reads must finish before error beats start
                if (r_cnt == '0) begin
                    w_state_nxt = ERR;
                end
            end
            ERR: begin
                w_s_rvalid = w_eb_valid;
                w_m_rready = 1'b0;
                if (w_eb_done) begin
                    w_state_nxt = PASS;
                end
            end
            default: begin
                w_state_nxt = PASS;
            end
        endcase

        if (rst) begin
            w_s_arready = 1'b0;
            w_m_arvalid = 1'b0;
            w_s_rvalid  = 1'b0;
            w_m_rready  = 1'b0;
            w_err_load  = 1'b0;
        end
    end

    assign w_ar_hs     = w_m_arvalid && m_axi.arready;
    assign w_r_last_hs = m_axi.rvalid && w_m_rready && m_axi.rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            unique case ({w_ar_hs, w_r_last_hs})
                2'b10: r_cnt <= r_cnt + 1'b1;
                2'b01: r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_no_orphan_rlast: assert property (@(posedge clk) disable iff (rst)
        !(w_r_last_hs && (r_cnt == '0)));

endmodule : axi_io_pmp_rd_filter
`default_nettype wire

// File: tb/tb_axi_io_pmp_rd_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_io_pmp_rd_filter
// Purpose  : Directed self-checking bench for the IO-PMP read filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_io_pmp_rd_filter;

    localparam int DW   = 64;
    localparam int AW   = 64;
    localparam int IW   = 8;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] pmp_addr;
    logic        pmp_allow;
    logic [1:0]  outstanding;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_io_pmp_rd_filter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s_if ();
    axi_io_pmp_rd_filter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_if ();

    axi_io_pmp_rd_filter #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .ID_WIDTH        (IW),
        .ARUSER_WIDTH    (1),
        .RUSER_WIDTH     (1),
        .PLEN            (56),
        .MAX_OUTSTANDING (MAXO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi         (s_if),
        .m_axi         (m_if),
        .pmp_addr_o    (pmp_addr),
        .pmp_allow_i   (pmp_allow),
        .outstanding_o (outstanding)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ar(input logic [7:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic user, input logic allow);
        s_if.arvalid = 1'b1;
        s_if.arid    = id;
        s_if.araddr  = addr;
        s_if.arlen   = len;
        s_if.aruser  = user;
        pmp_allow    = allow;
    endtask

    task automatic drive_mr(input logic valid, input logic [7:0] id,
                            input logic [63:0] data, input logic last);
        m_if.rvalid = valid;
        m_if.rid    = id;
        m_if.rdata  = data;
        m_if.rresp  = 2'b00;
        m_if.rlast  = last;
        m_if.ruser  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        logic pat [4];
        int   hs;
        int   waited;

        rst = 1'b1;
        s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = 3'd3;
        s_if.arburst = 2'b01; s_if.arlock = 1'b0; s_if.arcache = 4'h2;
        s_if.arprot = 3'b010; s_if.arqos = 4'h5; s_if.arregion = 4'h9;
        s_if.aruser = 1'b0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
        m_if.arready = 1'b0;
        drive_mr(1'b0, 8'h00, 64'h0, 1'b0);
        pmp_allow = 1'b0;

        // Reset: every handshake output must be held low despite active inputs
        step(); step();
        drive_ar(8'h01, 64'h0, 8'h00, 1'b0, 1'b1);
        m_if.arready = 1'b1;
        s_if.rready  = 1'b1;
        m_if.rvalid  = 1'b1;
        #1;
        check("rst_arready", s_if.arready, 0);
        check("rst_m_arvalid", m_if.arvalid, 0);
        check("rst_s_rvalid", s_if.rvalid, 0);
        check("rst_m_rready", m_if.rready, 0);
        check("rst_outstanding", outstanding, 0);
        s_if.arvalid = 1'b0;
        m_if.rvalid  = 1'b0;
        rst = 1'b0;
        step();

        // Allowed single read
        drive_ar(8'h12, 64'hAB00_1234_5678_9ABC, 8'h00, 1'b1, 1'b1);
        #1;
        check("t1_m_arvalid", m_if.arvalid, 1);
        check("t1_s_arready", s_if.arready, 1);
        check("t1_m_arid", m_if.arid, 8'h12);
        check("t1_m_araddr", m_if.araddr, 64'hAB00_1234_5678_9ABC);
        check("t1_m_arregion", m_if.arregion, 4'h9);
        check("t1_pmp_addr", pmp_addr, 56'h00_1234_5678_9ABC);
        check("t1_out0", outstanding, 0);
        step();
        s_if.arvalid = 1'b0;
        check("t1_out1", outstanding, 1);
        drive_mr(1'b1, 8'h12, 64'hDEAD_BEEF_0123_4567, 1'b1);
        #1;
        check("t1_s_rvalid", s_if.rvalid, 1);
        check("t1_s_rid", s_if.rid, 8'h12);
        check("t1_s_rdata", s_if.rdata, 64'hDEAD_BEEF_0123_4567);
        check("t1_s_rlast", s_if.rlast, 1);
        check("t1_m_rready", m_if.rready, 1);
        step();
        m_if.rvalid = 1'b0;
        check("t1_out_back0", outstanding, 0);

        // Denied burst with nothing outstanding: straight to error beats
        drive_ar(8'h05, 64'h40, 8'd3, 1'b1, 1'b0);
        #1;
        check("t2_s_arready", s_if.arready, 1);
        check("t2_m_arvalid", m_if.arvalid, 0);
        step();
        s_if.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_rvalid", s_if.rvalid, 1);
            check("t2_rid", s_if.rid, 8'h05);
            check("t2_rresp", s_if.rresp, 2'b11);
            check("t2_rdata", s_if.rdata, 64'h0);
            check("t2_ruser", s_if.ruser, 1);
            check("t2_rlast", s_if.rlast, (i == 3) ? 1 : 0);
            check("t2_m_arvalid", m_if.arvalid, 0);
            step();
        end
        #1;
        check("t2_done_rvalid", s_if.rvalid, 0);

        // Backpressure during a two-beat error burst
        drive_ar(8'h3C, 64'h80, 8'd1, 1'b0, 1'b0);
        #1;
        check("t4_s_arready", s_if.arready, 1);
        step();
        s_if.arvalid = 1'b0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            s_if.rready = pat[i];
            #1;
            check("t4_rvalid", s_if.rvalid, 1);
            check("t4_rid", s_if.rid, 8'h3C);
            check("t4_rlast", s_if.rlast, (i >= 1) ? 1 : 0);
            if (s_if.rvalid && s_if.rready) hs++;
            step();
        end
        s_if.rready = 1'b1;
        #1;
        check("t4_after_rvalid", s_if.rvalid, 0);
        check("t4_beats", hs, 2);

        // Denied read behind two outstanding forwarded reads
        drive_ar(8'h21, 64'h1000, 8'd0, 1'b0, 1'b1);
        m_if.arready = 1'b1;
        step();
        s_if.arid = 8'h22;
        step();
        s_if.arvalid = 1'b0;
        check("t3_out2", outstanding, 2);
        drive_ar(8'h0A, 64'h2000, 8'd1, 1'b0, 1'b0);
        #1;
        check("t3_deny_arready", s_if.arready, 1);
        check("t3_deny_m_arvalid", m_if.arvalid, 0);
        step();
        drive_ar(8'h77, 64'h3000, 8'd0, 1'b0, 1'b1);
        #1;
        check("t3_drain_arready", s_if.arready, 0);
        check("t3_drain_m_arvalid", m_if.arvalid, 0);
        check("t3_drain_rvalid", s_if.rvalid, 0);
        drive_mr(1'b1, 8'h21, 64'hA1, 1'b1);
        #1;
        check("t3_r1_rid", s_if.rid, 8'h21);
        check("t3_r1_rdata", s_if.rdata, 64'hA1);
        check("t3_r1_m_rready", m_if.rready, 1);
        step();
        drive_mr(1'b1, 8'h22, 64'hA2, 1'b1);
        #1;
        check("t3_r2_rid", s_if.rid, 8'h22);
        check("t3_r2_rresp", s_if.rresp, 2'b00);
        step();
        m_if.rvalid  = 1'b0;
        s_if.arvalid = 1'b0;
        #1;
        check("t3_out0", outstanding, 0);
        check("t3_no_early_err", s_if.rvalid, 0);
        waited = 0;
        while (s_if.rvalid !== 1'b1 && waited < 6) begin
            step();
            #1;
            waited++;
        end
        check("t3_err_arrives", s_if.rvalid, 1);
        check("t3_err_rid", s_if.rid, 8'h0A);
        check("t3_err_rresp", s_if.rresp, 2'b11);
        check("t3_err_rlast0", s_if.rlast, 0);
        step();
        #1;
        check("t3_err_rlast1", s_if.rlast, 1);
        step();
        #1;
        check("t3_err_done", s_if.rvalid, 0);

        // Outstanding cap of two: third AR stalls until a read completes
        drive_ar(8'h01, 64'h4000, 8'd0, 1'b0, 1'b1);
        step();
        s_if.arid = 8'h02;
        step();
        s_if.arid = 8'h03;
        #1;
        check("t5_out2", outstanding, 2);
        check("t5_stall_arready", s_if.arready, 0);
        check("t5_stall_m_arvalid", m_if.arvalid, 0);
        step();
        check("t5_stall2_arready", s_if.arready, 0);
        drive_mr(1'b1, 8'h01, 64'hB1, 1'b1);
        #1;
        check("t5_stall3_arready", s_if.arready, 0);
        step();
        m_if.rvalid = 1'b0;
        #1;
        check("t5_out1", outstanding, 1);
        check("t5_go_arready", s_if.arready, 1);
        check("t5_go_m_arvalid", m_if.arvalid, 1);
        check("t5_go_m_arid", m_if.arid, 8'h03);
        step();
        s_if.arvalid = 1'b0;
        check("t5_out2b", outstanding, 2);
        drive_mr(1'b1, 8'h02, 64'hB2, 1'b1);
        step();
        drive_mr(1'b1, 8'h03, 64'hB3, 1'b1);
        step();
        m_if.rvalid = 1'b0;
        check("t5_out0", outstanding, 0);

        // Reset in the middle of a four-beat error burst
        drive_ar(8'h44, 64'h5000, 8'd3, 1'b1, 1'b0);
        step();
        s_if.arvalid = 1'b0;
        #1;
        check("t6_beat1_rid", s_if.rid, 8'h44);
        step();
        #1;
        check("t6_beat2_rvalid", s_if.rvalid, 1);
        check("t6_beat2_rlast", s_if.rlast, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_rvalid", s_if.rvalid, 0);
        step();
        rst = 1'b0;
        #1;
        check("t6_post_rvalid", s_if.rvalid, 0);
        check("t6_post_out", outstanding, 0);
        drive_ar(8'h55, 64'h6000, 8'd0, 1'b0, 1'b1);
        #1;
        check("t6_fwd_m_arvalid", m_if.arvalid, 1);
        check("t6_fwd_m_arid", m_if.arid, 8'h55);
        step();
        s_if.arvalid = 1'b0;
        check("t6_fwd_out1", outstanding, 1);
        drive_mr(1'b1, 8'h55, 64'hC5, 1'b1);
        step();
        m_if.rvalid = 1'b0;
        check("t6_fwd_out0", outstanding, 0);
        drive_ar(8'h66, 64'h7000, 8'd1, 1'b0, 1'b0);
        step();
        s_if.arvalid = 1'b0;
        #1;
        check("t6_new_rid", s_if.rid, 8'h66);
        check("t6_new_rlast0", s_if.rlast, 0);
        step();
        #1;
        check("t6_new_rlast1", s_if.rlast, 1);
        step();
        #1;
        check("t6_new_done", s_if.rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_io_pmp_rd_filter
`default_nettype wire

// File: doc/axi_io_pmp_rd_filter.md
Name: axi_io_pmp_rd_filter

Overview:
- Read-path enforcement stage; sits directly downstream of the AR/R register slice on the slave side of the IO-PMP.
- Presents each incoming AR address to the PMP checker and reads back its combinational verdict.
- Forwards allowed ARs to the master port.
- Absorbs denied ARs and answers them locally with a full-length DECERR burst, so the master-side interconnect never sees a denied read.

Parameters:
- DATA_WIDTH, 64, R data width in bits
- ADDR_WIDTH, 64, AR address width
- ID_WIDTH, 8, AXI ID width
- ARUSER_WIDTH, 1, aruser width
- RUSER_WIDTH, 1, ruser width
- PLEN, 56, physical address bits sent to the checker
- MAX_OUTSTANDING, 8, cap on forwarded reads awaiting their last R beat

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/ARUSER_WIDTH  upstream AR payload
- s_axi_arvalid  in  1 / s_axi_arready  out  1
- s_axi_r{id,data,resp,last,user}  out  ID_WIDTH/DATA_WIDTH/2/1/RUSER_WIDTH  upstream R payload
- s_axi_rvalid  out  1 / s_axi_rready  in  1
- m_axi_ar*  out  same widths as s_axi_ar*  downstream AR; m_axi_arvalid out 1, m_axi_arready in 1
- m_axi_r*  in  same widths as s_axi_r*  downstream R; m_axi_rvalid in 1, m_axi_rready out 1
- pmp_addr_o  out  PLEN  always s_axi_araddr[PLEN-1:0]
- pmp_allow_i  in  1  combinational verdict for pmp_addr_o, same cycle
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current forwarded-read count (debug)

Behaviour:
- States: PASS, DRAIN, ERR. Reset: state=PASS, cnt=0, beat=0, captured id/len/user=0.
- While rst=1: s_axi_arready=0, m_axi_arvalid=0, s_axi_rvalid=0, m_axi_rready=0.
- PASS, allowed (pmp_allow_i=1):
  - m_axi_arvalid = s_axi_arvalid && cnt<MAX_OUTSTANDING.
  - s_axi_arready = m_axi_arready && cnt<MAX_OUTSTANDING.
  - AR payload passes combinationally, zero latency.
- PASS, denied (pmp_allow_i=0):
  - s_axi_arready=1, m_axi_arvalid=0.
  - On handshake, capture arid, arlen, aruser.
  - Next state is ERR if cnt==0, else DRAIN. Skipping DRAIN when cnt==0 avoids a dead cycle.
- DRAIN:
  - s_axi_arready=0, m_axi_arvalid=0.
  - Master R passes through.
  - Move to ERR on the cycle after cnt reaches 0. This keeps R responses in order and prevents error and forwarded beats from interleaving.
- ERR:
  - s_axi_rvalid=1, rid=captured id, rdata=0, rresp=2'b11 (DECERR), ruser=captured user.
  - s_axi_rlast = (beat==captured len).
  - m_axi_rready=0; s_axi_arready=0.
  - beat increments on each s_axi_rvalid&&s_axi_rready.
  - On the last-beat handshake: beat clears to 0, state returns to PASS.
  - Beat count is always arlen+1. arlen=255 yields 256 beats; beat is 8 bits and wraps to 0 at exit.
- R pass-through (PASS, DRAIN): s_axi_r* = m_axi_r*, m_axi_rready = s_axi_rready.
- Outstanding counter cnt:
  - +1 on m_axi_arvalid&&m_axi_arready.
  - -1 on m_axi_rvalid&&m_axi_rready&&m_axi_rlast.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows. A last beat with cnt==0 is a protocol error: flag via assertion, cnt holds at 0.
- Verdict timing: pmp_allow_i is sampled only at the AR handshake. If pmp config changes while arvalid is stalled, the verdict at the handshake wins.
- Reset mid-burst: everything returns to reset values next cycle. The partially sent error burst is abandoned, not completed.
- No write-channel involvement. The write path is a separate sibling block.

Decomposition:
- Shared package axi_io_pmp_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - state enum rd_filter_state_e {PASS, DRAIN, ERR}
  - PLEN/PMP_LEN constants, shared with the top level
- One natural sub-module: axi_io_pmp_err_burst. It holds the ERR-state beat counter and the rlast/resp generator, and will be reused by the future write filter for B responses.

Test Plan:
- Allowed single read: arid=0x12, arlen=0, allow=1 -> m_axi_arvalid in the same cycle; one R beat from the master passes unchanged; outstanding goes 0->1->0.
- Denied burst: arid=0x05, arlen=3, allow=0, cnt=0 -> AR accepted in 1 cycle; 4 beats rid=0x05, rresp=2'b11, rdata=0, rlast only on beat 4; m_axi_arvalid never asserted.
- Denied read behind outstanding: 2 allowed reads pending, then a denied AR -> state DRAIN; error beats start only after both master rlast handshakes; no interleaving.
- Backpressure: s_axi_rready toggling 1,0,0,1 during a denied arlen=1 burst -> rvalid held, payload stable, exactly 2 beats.
- Outstanding cap with MAX_OUTSTANDING=2: 3 allowed ARs, master withholds R -> third AR stalls with s_axi_arready=0 until the first rlast, then forwards.
- Reset during ERR beat 2 of 4 -> next cycle s_axi_rvalid=0, state PASS, cnt=0; a new allowed AR forwards normally.
